// File: rtl/mux_pipe.sv
`default_nettype none
// mux_pipe: registered N:1 word mux behind a two-entry skid buffer (output + skid entry).
// Optional sticky out-of-range-select flag enabled by defining MUX_PIPE_SELERR_EN.
module mux_pipe #(
  parameter int                WIDTH       = 32,
  parameter int                NUM_IN      = 4,
  parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0,
  localparam int               SEL_W       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [NUM_IN*WIDTH-1:0]   data_i,
  input  logic [SEL_W-1:0]          select_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [WIDTH-1:0]          data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      sel_err_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] sel_word;
  logic             accept;
  logic             drain;

  assign accept = valid_i && ready_o;
  assign drain  = valid_o && ready_i;

  // Unmatched selects fall through to DEFAULT_VAL, so the output is never X.
  always_comb begin
    sel_word = DEFAULT_VAL;
    for (int k = 0; k < NUM_IN; k++) begin
      if (select_i == SEL_W'(k)) begin
        sel_word = data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= EMPTY;
      data_o    <= '0;
      skid_data <= '0;
      valid_o   <= 1'b0;
      ready_o   <= 1'b1;
    end else if (flush_i) begin
      state   <= EMPTY;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            data_o  <= sel_word;
            valid_o <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            data_o <= sel_word;
          end else if (accept) begin
            // Output entry is stalled; park the new word and stop accepting.
            skid_data <= sel_word;
            ready_o   <= 1'b0;
            state     <= TWO;
          end else if (drain) begin
            valid_o <= 1'b0;
            state   <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            data_o  <= skid_data;
            ready_o <= 1'b1;
            state   <= ONE;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

`ifdef MUX_PIPE_SELERR_EN
  logic sel_err;
  logic in_range;

  assign in_range  = int'(select_i) < NUM_IN;
  assign sel_err_o = sel_err;

  // Sticky until reset; flush leaves it alone.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sel_err <= 1'b0;
    end else if (accept && !in_range) begin
      sel_err <= 1'b1;
    end
  end
`else
  assign sel_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_pipe.sv
`default_nettype none
// tb_mux_pipe: scoreboard bench; two instances (4 inputs, and 3 inputs with DEFAULT_VAL=0xDEAD).
module tb_mux_pipe;

`ifdef MUX_PIPE_SELERR_EN
  localparam logic SELERR_EXP = 1'b1;
`else
  localparam logic SELERR_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         flush0, flush1;
  logic [127:0] data0;
  logic [95:0]  data1;
  logic [1:0]   sel0, sel1;
  logic         valid0, valid1;
  logic         rdy_up0, rdy_up1;
  logic [31:0]  dout0, dout1;
  logic         vout0, vout1;
  logic         rdy_dn0, rdy_dn1;
  logic         err0, err1;

  int errors = 0;
  int checks = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  mux_pipe #(.WIDTH(32), .NUM_IN(4), .DEFAULT_VAL(32'h0)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush0), .data_i(data0), .select_i(sel0),
    .valid_i(valid0), .ready_o(rdy_up0), .data_o(dout0), .valid_o(vout0),
    .ready_i(rdy_dn0), .sel_err_o(err0)
  );

  mux_pipe #(.WIDTH(32), .NUM_IN(3), .DEFAULT_VAL(32'hDEAD)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush1), .data_i(data1), .select_i(sel1),
    .valid_i(valid1), .ready_o(rdy_up1), .data_o(dout1), .valid_o(vout1),
    .ready_i(rdy_dn1), .sel_err_o(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Put word on input 'sel', distinct filler elsewhere.
  task automatic offer0(input logic [31:0] word, input logic [1:0] sel);
    for (int k = 0; k < 4; k++) begin
      data0[k*32 +: 32] = (k == int'(sel)) ? word : (32'hFFFF_0000 | 32'(k));
    end
    sel0   = sel;
    valid0 = 1'b1;
  endtask

  // Monitors: a drain happens at the next edge whenever valid_o && ready_i here.
  always @(negedge clk) begin
    if (rst && !flush0 && vout0 && rdy_dn0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_unexpected_word: got %h expected none", dout0);
      end else begin
        chk("dut0_order", dout0, q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst && !flush1 && vout1 && rdy_dn1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_word: got %h expected none", dout1);
      end else begin
        chk("dut1_order", dout1, q1.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
    data0 = '0; sel0 = '0; valid0 = 1'b0; rdy_dn0 = 1'b1;
    data1 = {32'hC2, 32'hC1, 32'hC0}; sel1 = '0; valid1 = 1'b0; rdy_dn1 = 1'b1;
    tick; tick;
    chk("rst_valid0", 32'(vout0), 32'd0);
    chk("rst_ready0", 32'(rdy_up0), 32'd1);
    chk("rst_data0", dout0, 32'h0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_valid1", 32'(vout1), 32'd0);
    rst = 1'b1;
    tick;

    // Basic capture of input 2
    data0 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    sel0 = 2'd2; valid0 = 1'b1;
    chk("basic_ready_before", 32'(rdy_up0), 32'd1);
    q0.push_back(32'hA2);
    tick;
    chk("basic_valid", 32'(vout0), 32'd1);
    chk("basic_data", dout0, 32'hA2);
    chk("basic_ready_after", 32'(rdy_up0), 32'd1);
    valid0 = 1'b0;
    tick;
    chk("basic_drained", 32'(vout0), 32'd0);

    // Streaming through ONE with accept and drain each cycle
    for (int i = 0; i < 3; i++) begin
      logic [1:0] s;
      s = (i == 0) ? 2'd0 : (i == 1) ? 2'd3 : 2'd1;
      offer0(32'h1000 + 32'(i), s);
      q0.push_back(32'h1000 + 32'(i));
      tick;
      chk("stream_ready", 32'(rdy_up0), 32'd1);
    end
    valid0 = 1'b0;
    tick;

    // Backpressure: 3 words offered with ready_i=0
    rdy_dn0 = 1'b0;
    offer0(32'h11, 2'd1); q0.push_back(32'h11);
    tick;
    offer0(32'h22, 2'd2); q0.push_back(32'h22);
    tick;
    chk("bp_ready_low", 32'(rdy_up0), 32'd0);
    offer0(32'h33, 2'd3); q0.push_back(32'h33);
    tick;
    chk("bp_hold_data", dout0, 32'h11);
    chk("bp_hold_valid", 32'(vout0), 32'd1);
    chk("bp_ready_still_low", 32'(rdy_up0), 32'd0);
    rdy_dn0 = 1'b1;
    tick;
    chk("bp_second_word", dout0, 32'h22);
    tick;
    valid0 = 1'b0;
    chk("bp_third_word", dout0, 32'h33);
    tick;
    chk("bp_empty", 32'(vout0), 32'd0);

    // Flush in TWO with a concurrent offer
    rdy_dn0 = 1'b0;
    offer0(32'h55, 2'd0);
    tick;
    offer0(32'h66, 2'd1);
    tick;
    chk("flush_in_two", 32'(rdy_up0), 32'd0);
    flush0 = 1'b1;
    offer0(32'h67, 2'd2);
    tick;
    flush0 = 1'b0; valid0 = 1'b0;
    chk("flush_valid", 32'(vout0), 32'd0);
    chk("flush_ready", 32'(rdy_up0), 32'd1);
    // Flush in ONE while a word is being accepted
    offer0(32'h99, 2'd3);
    tick;
    flush0 = 1'b1;
    offer0(32'hAA, 2'd0);
    tick;
    flush0 = 1'b0; valid0 = 1'b0;
    chk("flush1_valid", 32'(vout0), 32'd0);
    chk("flush1_ready", 32'(rdy_up0), 32'd1);
    rdy_dn0 = 1'b1;
    tick; tick;
    offer0(32'h88, 2'd2); q0.push_back(32'h88);
    tick;
    valid0 = 1'b0;
    tick;

    // Out-of-range select on the 3-input instance
    sel1 = 2'd3; valid1 = 1'b1; q1.push_back(32'hDEAD);
    tick;
    chk("oor_data", dout1, 32'hDEAD);
    chk("oor_selerr", 32'(err1), 32'(SELERR_EXP));
    sel1 = 2'd1; q1.push_back(32'hC1);
    tick;
    valid1 = 1'b0;
    chk("inrange_data", dout1, 32'hC1);
    chk("selerr_sticky", 32'(err1), 32'(SELERR_EXP));
    tick;

    // Reset while in TWO with a word offered
    rdy_dn0 = 1'b0;
    offer0(32'h5A, 2'd0);
    tick;
    offer0(32'h5B, 2'd1);
    tick;
    rst = 1'b0;
    offer0(32'h5C, 2'd2);
    tick;
    rst = 1'b1; valid0 = 1'b0;
    chk("mid_rst_valid", 32'(vout0), 32'd0);
    chk("mid_rst_data", dout0, 32'h0);
    chk("mid_rst_ready", 32'(rdy_up0), 32'd1);
    chk("mid_rst_err0", 32'(err0), 32'd0);
    chk("mid_rst_err1", 32'(err1), 32'd0);
    rdy_dn0 = 1'b1;
    tick; tick; tick;
    offer0(32'h77, 2'd3); q0.push_back(32'h77);
    tick;
    valid0 = 1'b0;
    repeat (4) tick;

    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("err0_never", 32'(err0), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_pipe.md
MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of each input and of the output.
REQ-002 SHALL have parameter NUM_IN, default 4: number of data inputs, legal range 2..16.
REQ-003 SHALL have parameter DEFAULT_VAL, default 0: value routed when the select is out of range.
REQ-004 SHALL derive localparam SEL_W = ceil(log2(NUM_IN)); it is not overridable.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port flush_i, input, 1: discards all buffered words.
REQ-008 SHALL have port data_i, input, NUM_IN*WIDTH: packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port select_i, input, SEL_W: index of the input to capture.
REQ-010 SHALL have port valid_i, input, 1: upstream word valid.
REQ-011 SHALL have port ready_o, output, 1: block can accept a word.
REQ-012 SHALL have port data_o, output, WIDTH: registered selected word.
REQ-013 SHALL have port valid_o, output, 1: data_o holds a valid word.
REQ-014 SHALL have port ready_i, input, 1: downstream accepts data_o.
REQ-015 SHALL have port sel_err_o, output, 1: sticky out-of-range-select flag (see Configuration).

Function
REQ-016 SHALL define accept as valid_i && ready_o and drain as valid_o && ready_i, both sampled at the rising clock edge.
REQ-017 SHALL capture input select_i when select_i < NUM_IN, and DEFAULT_VAL otherwise; the output is never X.
REQ-018 SHALL hold two registered entries (output entry, skid entry) and track occupancy with states EMPTY, ONE and TWO.
REQ-019 SHALL transition from EMPTY to ONE on accept; accept-to-valid_o latency is 1 cycle.
REQ-020 SHALL stay in ONE on accept with drain, loading the new word into the output entry.
REQ-021 SHALL transition from ONE to TWO on accept without drain, storing the word in the skid entry.
REQ-022 SHALL transition from ONE to EMPTY on drain without accept.
REQ-023 SHALL transition from TWO to ONE on drain, moving the skid entry to the output entry.
REQ-024 SHALL drive ready_o from a register: 1 in EMPTY and ONE, 0 in TWO, so no accept occurs in TWO.
REQ-025 SHALL preserve acceptance order; no word is duplicated or dropped except by flush or reset.
REQ-026 SHALL hold data_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-027 SHALL, on flush_i=1, go to EMPTY next cycle with valid_o=0 and ready_o=1; flush has priority over a simultaneous accept or drain, and the concurrent input word is discarded.
REQ-028 SHALL leave data_o unchanged when a cycle has no accept, drain or flush.

Reset
REQ-029 SHALL, while rst_i=0 at a rising edge, set state EMPTY, data_o=0, valid_o=0, ready_o=1, skid entry=0 and sel_err_o=0.
REQ-030 SHALL give reset priority over flush, accept and drain; words offered during reset are discarded, including mid-transfer.

Configuration
REQ-031 SHALL, when macro MUX_PIPE_SELERR_EN is defined, set sel_err_o to 1 on any accept with select_i >= NUM_IN and hold it until reset; flush does not clear it.
REQ-032 SHALL, when MUX_PIPE_SELERR_EN is undefined, tie sel_err_o to 0 and implement no error logic; all data-path behaviour is identical in both builds.

Verification
REQ-033 SHALL cover: WIDTH=32, NUM_IN=4, data_i inputs {0xA0,0xA1,0xA2,0xA3}, select_i=2, valid_i=1, ready_i=1 -> data_o=0xA2 with valid_o=1 one cycle later and ready_o=1 throughout.
REQ-034 SHALL cover: ready_i=0 with 3 words offered back-to-back (0x11,0x22,0x33) -> ready_o=0 after the second accept and 0x33 held upstream; after ready_i=1, data_o shows 0x11, then 0x22, then 0x33 in order.
REQ-035 SHALL cover: state TWO with flush_i=1 and valid_i=1 in the same cycle -> next cycle valid_o=0 and ready_o=1, and the flushed and concurrent words never appear.
REQ-036 SHALL cover: NUM_IN=3 with DEFAULT_VAL=0xDEAD and select_i=3 accepted -> data_o=0xDEAD; sel_err_o=1 with MUX_PIPE_SELERR_EN defined and 0 without it.
REQ-037 SHALL cover: rst_i=0 for one cycle while in TWO with valid_i=1 -> next cycle valid_o=0, data_o=0, ready_o=1 and sel_err_o=0.
